// File: rtl/nco_gen.sv
// nco_gen -- numerically controlled oscillator for the BPSK carrier path.
//
// A phase accumulator steps by FREQ_BASE + (diff <<< DIFF_SHIFT) on every
// valid sample. A static phase offset is added, and the top ADDR_W phase bits
// address a quarter-wave sine table. The result is quadrature sine/cosine from
// a registered 3-stage pipeline. All arithmetic wraps modulo 2^PHASE_W.
//
// Ports:
//   clk        clock, all state on the rising edge
//   reset      asynchronous, active-low reset
//   in_valid   sample strobe; the accumulator steps only when high
//   diff       signed frequency offset (scaled by 2^DIFF_SHIFT)
//   phase_offs unsigned phase offset, added after the accumulator
//   sync_clr   synchronous accumulator clear
//   out_valid  sin_out/cos_out carry a new sample this cycle
//   phase      accumulator value (stage-0 register)
//   sin_out    signed sine, OUT_W bits
//   cos_out    signed cosine, OUT_W bits
//
// Optional feature macro: NCO_DITHER_EN. When it is defined, a 16-bit LFSR
// adds phase dither below the address bits before truncation.

module nco_gen #(
    parameter int                 PHASE_W    = 32,
    parameter logic [PHASE_W-1:0] FREQ_BASE  = PHASE_W'(429496729),
    parameter int                 DIFF_SHIFT = 3,
    parameter int                 ADDR_W     = 10,
    parameter int                 OUT_W      = 16,
    parameter string              LUT_FILE   = "sin_quarter.hex"
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [PHASE_W-1:0]        diff,
    input  logic [PHASE_W-1:0]        phase_offs,
    input  logic                      sync_clr,
    output logic                      out_valid,
    output logic [PHASE_W-1:0]        phase,
    output logic signed [OUT_W-1:0]   sin_out,
    output logic signed [OUT_W-1:0]   cos_out
);

    localparam int Q   = 1 << (ADDR_W - 2);
    localparam int AMP = (1 << (OUT_W - 1)) - 1;

    // Quarter-table entry T[k] = round(AMP * sin(pi*(2k+1)/2^ADDR_W)).
    // The table is evaluated at elaboration with a 60-bit fixed-point Taylor
    // series, so the ROM contents need no external image. Terms stay positive
    // because the angle never exceeds pi/2. Their signs alternate by index.
    function automatic logic [OUT_W-1:0] sin_entry(input int k);
        logic [127:0] pi_fx;
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum;
        logic [127:0] v;
        pi_fx = 128'h3243F6A8885A308D;
        x     = (pi_fx * 128'(2 * k + 1)) >> ADDR_W;
        x2    = (x * x) >> 60;
        term  = x;
        sum   = x;
        for (int n = 1; n <= 12; n++) begin
            term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
            if (n % 2 == 1)
                sum = sum - term;
            else
                sum = sum + term;
        end
        v = sum * 128'(AMP);
        v = (v + (128'd1 << 59)) >> 60;
        return v[OUT_W-1:0];
    endfunction

    logic signed [OUT_W-1:0] quarter [Q];

    for (genvar g = 0; g < Q; g++) begin : g_rom
        assign quarter[g] = sin_entry(g);
    end

    // The table is generated here. LUT_FILE only names the image that
    // file-based ROM flows would load.
    if (LUT_FILE == "") begin : g_lut_name_unset
    end

    logic [PHASE_W-1:0] step;
    assign step = FREQ_BASE + (diff << DIFF_SHIFT);

    // Phase dither added below the address bits at stage 1
`ifdef NCO_DITHER_EN
    localparam int DW = ((PHASE_W - ADDR_W) < 16) ? (PHASE_W - ADDR_W) : 16;

    logic [15:0]        lfsr;
    logic [PHASE_W-1:0] dither;

    assign dither = PHASE_W'(lfsr[DW-1:0]);

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, one step per accepted sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr <= 16'hACE1;
        else if (in_valid)
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
`else
    logic [PHASE_W-1:0] dither;
    assign dither = '0;
`endif

    logic                    v0;
    logic                    v1;
    logic                    v2;
    logic [ADDR_W-1:0]       p1;
    logic [PHASE_W-1:0]      p1_sum;
    logic [ADDR_W-3:0]       k1;
    logic [1:0]              q2;
    logic signed [OUT_W-1:0] rom_a;
    logic signed [OUT_W-1:0] rom_b;

    // Stage 0: accumulator. A clear combined with a sample loads the step
    // directly, so that sample's phase is S rather than 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= '0;
            v0    <= 1'b0;
        end else begin
            v0 <= in_valid;
            if (sync_clr && in_valid)
                phase <= step;
            else if (sync_clr)
                phase <= '0;
            else if (in_valid)
                phase <= phase + step;
        end
    end

    // Stage 1: add offset and dither, keep only the lookup address bits
    assign p1_sum = phase + phase_offs + dither;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= v0;
            if (v0)
                p1 <= ADDR_W'(p1_sum >> (PHASE_W - ADDR_W));
        end
    end

    // Stage 2: read T[k] and the mirrored entry T[Q-1-k] (bitwise complement)
    assign k1 = p1[ADDR_W-3:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q2    <= '0;
            rom_a <= '0;
            rom_b <= '0;
            v2    <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                q2    <= p1[ADDR_W-1 -: 2];
                rom_a <= quarter[k1];
                rom_b <= quarter[~k1];
            end
        end
    end

    // Stage 3: quadrant selection and sign. Table entries never reach
    // -2^(OUT_W-1), so negation cannot overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sin_out   <= '0;
            cos_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                case (q2)
                    2'd0: begin
                        sin_out <= rom_a;
                        cos_out <= rom_b;
                    end
                    2'd1: begin
                        sin_out <= rom_b;
                        cos_out <= -rom_a;
                    end
                    2'd2: begin
                        sin_out <= -rom_a;
                        cos_out <= -rom_b;
                    end
                    default: begin
                        sin_out <= -rom_b;
                        cos_out <= rom_a;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nco_gen.sv
// tb_nco_gen -- directed, self-checking bench for nco_gen with default
// parameters. Expected sine/cosine values come from a real-valued model of
// the quarter table, and from hand-derived constants for the quadrant points.
// Build with +define+NCO_DITHER_EN to exercise the dithered variant.
//
// Ports of the DUT are all driven or observed here. No ports of its own.

module tb_nco_gen;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic [31:0]        diff;
    logic [31:0]        phase_offs;
    logic               sync_clr;
    logic               out_valid;
    logic [31:0]        phase;
    logic signed [15:0] sin_out;
    logic signed [15:0] cos_out;

    int n_vec  = 0;
    int n_miss = 0;

    // diff that makes the step exactly 1, and diff that makes it 32'hFFFF_FFF9
    localparam logic [31:0] DIFF_S1   = 32'hFCCC_CCCD;
    localparam logic [31:0] DIFF_SF9  = 32'h1CCC_CCCC;

    nco_gen dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .diff       (diff),
        .phase_offs (phase_offs),
        .sync_clr   (sync_clr),
        .out_valid  (out_valid),
        .phase      (phase),
        .sin_out    (sin_out),
        .cos_out    (cos_out)
    );

    always #5 clk = ~clk;

    // Real-valued reference for the quarter table
    function automatic int t_val(input int k);
        real x;
        x = 3.14159265358979323846 * (2.0 * k + 1.0) / 1024.0;
        return $rtoi(32767.0 * $sin(x) + 0.5);
    endfunction

    // Expected sine/cosine for an (undithered) stage-1 phase
    function automatic void model(input logic [31:0] p,
                                  output logic signed [15:0] s,
                                  output logic signed [15:0] c);
        logic [9:0] a;
        int         ta;
        int         tb;
        a  = p[31:22];
        ta = t_val(int'(a[7:0]));
        tb = t_val(255 - int'(a[7:0]));
        case (a[9:8])
            2'd0:    begin s = 16'(ta);  c = 16'(tb);  end
            2'd1:    begin s = 16'(tb);  c = 16'(-ta); end
            2'd2:    begin s = 16'(-ta); c = 16'(-tb); end
            default: begin s = 16'(-tb); c = 16'(ta);  end
        endcase
    endfunction

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        in_valid   = 1'b0;
        sync_clr   = 1'b0;
        diff       = '0;
        phase_offs = '0;
        tick();
        tick();
        n_vec++;
        if (phase !== 32'd0) begin
            n_miss++;
            $display("[TB] FAIL reset_phase: got %0d expected 0", phase);
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_vec++;
        if (sin_out !== 16'sd0) begin
            n_miss++;
            $display("[TB] FAIL reset_sin: got %0d expected 0", sin_out);
        end
        n_vec++;
        if (cos_out !== 16'sd0) begin
            n_miss++;
            $display("[TB] FAIL reset_cos: got %0d expected 0", cos_out);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_first_sample();
        logic signed [15:0] es;
        logic signed [15:0] ec;
        in_valid = 1'b1;
        diff     = '0;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (phase !== 32'd429496729) begin
            n_miss++;
            $display("[TB] FAIL first_phase: got %0d expected 429496729", phase);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_vec++;
            if (out_valid !== (i == 3)) begin
                n_miss++;
                $display("[TB] FAIL first_latency_c%0d: got %b expected %b", i, out_valid, (i == 3));
            end
        end
        model(32'd429496729, es, ec);
        n_vec++;
        if (sin_out !== es || cos_out !== ec) begin
            n_miss++;
            $display("[TB] FAIL first_sincos: got %0d/%0d expected %0d/%0d", sin_out, cos_out, es, ec);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL first_pulse_end: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_sync_ramp();
        phase_offs = '0;
        diff       = DIFF_S1;
        sync_clr   = 1'b1;
        in_valid   = 1'b1;
        tick();
        sync_clr = 1'b0;
        n_vec++;
        if (phase !== 32'd1) begin
            n_miss++;
            $display("[TB] FAIL ramp_phase_1: got %0d expected 1", phase);
        end
        for (int j = 1; j <= 5; j++) begin
            tick();
            n_vec++;
            if (phase !== 32'(j + 1)) begin
                n_miss++;
                $display("[TB] FAIL ramp_phase_%0d: got %0d expected %0d", j + 1, phase, j + 1);
            end
            if (j >= 3) begin
                n_vec++;
                if (out_valid !== 1'b1 || sin_out !== 16'sd101 || cos_out !== 16'sd32767) begin
                    n_miss++;
                    $display("[TB] FAIL ramp_out_%0d: got v=%b %0d/%0d expected v=1 101/32767",
                             j, out_valid, sin_out, cos_out);
                end
            end
        end
        in_valid = 1'b0;
        repeat (3) tick();
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL ramp_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_quadrature();
        logic [31:0]        offs_tab [3];
        logic signed [15:0] sin_tab  [3];
        logic signed [15:0] cos_tab  [3];
        offs_tab = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
        sin_tab  = '{16'sd32767, -16'sd101, -16'sd32767};
        cos_tab  = '{-16'sd101, -16'sd32767, 16'sd101};
        for (int i = 0; i < 3; i++) begin
            phase_offs = offs_tab[i];
            diff       = DIFF_S1;
            sync_clr   = 1'b1;
            in_valid   = 1'b1;
            tick();
            sync_clr = 1'b0;
            in_valid = 1'b0;
            repeat (3) tick();
            n_vec++;
            if (out_valid !== 1'b1 || sin_out !== sin_tab[i] || cos_out !== cos_tab[i]) begin
                n_miss++;
                $display("[TB] FAIL quad_%0d: got v=%b %0d/%0d expected v=1 %0d/%0d",
                         i, out_valid, sin_out, cos_out, sin_tab[i], cos_tab[i]);
            end
            tick();
        end
        phase_offs = '0;
    endtask

    task automatic test_back_to_back_wrap();
        logic [31:0] exp_p;
        phase_offs = '0;
        diff       = DIFF_SF9;
        sync_clr   = 1'b1;
        in_valid   = 1'b1;
        tick();
        sync_clr = 1'b0;
        diff     = DIFF_S1;
        exp_p    = 32'hFFFF_FFF9;
        n_vec++;
        if (phase !== exp_p) begin
            n_miss++;
            $display("[TB] FAIL wrap_load: got %h expected %h", phase, exp_p);
        end
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp_p = exp_p + 32'd1;
            n_vec++;
            if (phase !== exp_p) begin
                n_miss++;
                $display("[TB] FAIL wrap_phase_%0d: got %h expected %h", i, phase, exp_p);
            end
            if (i >= 3) begin
                n_vec++;
                if (out_valid !== 1'b1) begin
                    n_miss++;
                    $display("[TB] FAIL wrap_valid_%0d: got %b expected 1", i, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        for (int i = 8; i <= 11; i++) begin
            tick();
            n_vec++;
            if (out_valid !== (i <= 10)) begin
                n_miss++;
                $display("[TB] FAIL wrap_drain_%0d: got %b expected %b", i, out_valid, (i <= 10));
            end
        end
    endtask

    task automatic test_reset_midstream();
        diff       = '0;
        phase_offs = '0;
        in_valid   = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (phase !== 32'd0 || sin_out !== 16'sd0 || cos_out !== 16'sd0 || out_valid !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL midreset_clear: got p=%0d s=%0d c=%0d v=%b expected all 0",
                     phase, sin_out, cos_out, out_valid);
        end
        #2;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_miss++;
                $display("[TB] FAIL midreset_no_valid_%0d: got %b expected 0", i, out_valid);
            end
        end
        n_vec++;
        if (phase !== 32'd0) begin
            n_miss++;
            $display("[TB] FAIL midreset_phase: got %0d expected 0", phase);
        end
    endtask

    task automatic test_gaps();
        logic               pattern [10];
        logic [31:0]        sample_p [2];
        logic [31:0]        acc_m;
        logic signed [15:0] es;
        logic signed [15:0] ec;
        logic signed [15:0] es2;
        logic signed [15:0] ec2;
        logic               ok;
        int                 n_in;
        int                 pulses;
        int                 pulse_idx;
        pattern   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        acc_m     = '0;
        n_in      = 0;
        pulses    = 0;
        pulse_idx = 0;
        diff       = '0;
        phase_offs = '0;
        for (int i = 0; i < 10; i++) begin
            in_valid = pattern[i];
            tick();
            if (pattern[i]) begin
                acc_m          = acc_m + 32'd429496729;
                sample_p[n_in] = acc_m;
                n_in++;
            end
            n_vec++;
            if (out_valid !== ((i >= 3) && pattern[i - 3])) begin
                n_miss++;
                $display("[TB] FAIL gaps_valid_%0d: got %b expected %b", i, out_valid, ((i >= 3) && pattern[i - 3]));
            end
            if (out_valid === 1'b1) begin
                pulses++;
                if (pulse_idx < 2) begin
                    model(sample_p[pulse_idx], es, ec);
                    model(sample_p[pulse_idx] + 32'h0040_0000, es2, ec2);
`ifdef NCO_DITHER_EN
                    ok = (sin_out === es && cos_out === ec) || (sin_out === es2 && cos_out === ec2);
`else
                    ok = (sin_out === es && cos_out === ec);
`endif
                    n_vec++;
                    if (!ok) begin
                        n_miss++;
                        $display("[TB] FAIL gaps_sincos_%0d: got %0d/%0d expected %0d/%0d (next step %0d/%0d)",
                                 pulse_idx, sin_out, cos_out, es, ec, es2, ec2);
                    end
                end
                pulse_idx++;
            end
            in_valid = 1'b0;
        end
        n_vec++;
        if (pulses != 2) begin
            n_miss++;
            $display("[TB] FAIL gaps_pulse_count: got %0d expected 2", pulses);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] nco_gen directed bench start");
        test_reset();
        test_first_sample();
        test_sync_ramp();
        test_quadrature();
        test_back_to_back_wrap();
        test_reset_midstream();
        test_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
